// File: rtl/crc_stream.sv
// Streaming CRC engine: forwards frames, then either appends the CRC (generate) or checks the
// trailing CRC (check). Optional saturating mismatch counter when CRC_ERRCNT_EN is defined.
module crc_stream #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     POLY    = 8'h39,
  parameter logic [WIDTH-1:0]     INIT    = 8'hFF,
  parameter logic [WIDTH-1:0]     XOROUT  = 8'h00,
  parameter logic [WIDTH-1:0]     RESIDUE = 8'h00,
  parameter int unsigned          DW      = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_check,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_last,
  output logic [WIDTH-1:0] crc_value,
  output logic             chk_valid,
  output logic             chk_ok
`ifdef CRC_ERRCNT_EN
  ,
  output logic [15:0]      err_count
`endif
);

  localparam int unsigned NChunk = WIDTH / DW;
  localparam int unsigned CntW   = (NChunk > 1) ? $clog2(NChunk) : 1;

  if ((DW > WIDTH) || ((WIDTH % DW) != 0)) begin : g_bad_dw
    $error("crc_stream: DW must divide WIDTH and not exceed it");
  end

  typedef enum logic [0:0] {StData, StAppend} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  crc_q, crc_d;
  logic [CntW-1:0]   chunk_q, chunk_d;
  logic              in_frame_q, in_frame_d;
  logic              mode_q, mode_d;
  logic              out_valid_q, out_valid_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              chk_valid_q, chk_valid_d;
  logic              chk_ok_q, chk_ok_d;
`ifdef CRC_ERRCNT_EN
  logic [15:0]       err_q, err_d;
`endif

  logic              out_free, accept, frame_mode, last_chunk;
  logic [WIDTH-1:0]  r_next;

  // DW serial steps, in_data MSB first.
  function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] r,
                                                input logic [DW-1:0] d);
    logic [WIDTH-1:0] c;
    c = r;
    for (int i = DW - 1; i >= 0; i--) begin
      c = (c << 1) ^ (((d[i] ^ c[WIDTH-1]) == 1'b1) ? POLY : '0);
    end
    return c;
  endfunction

  assign out_free   = !out_valid_q || out_ready;
  assign accept     = in_valid && in_ready;
  assign frame_mode = in_frame_q ? mode_q : mode_check;
  assign r_next     = crc_step(r_q, in_data);
  assign last_chunk = (chunk_q == CntW'(NChunk - 1));

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StData;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StData:   if (accept && in_last && !frame_mode) state_d = StAppend;
      StAppend: if (out_free && last_chunk)            state_d = StData;
      default:  state_d = StData;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == StData) && out_free;
  end

  always_comb begin
    r_d         = r_q;
    crc_d       = crc_q;
    chunk_d     = chunk_q;
    in_frame_d  = in_frame_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    chk_valid_d = 1'b0;
    chk_ok_d    = chk_ok_q;
`ifdef CRC_ERRCNT_EN
    err_d       = err_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data;
      out_last_d  = 1'b0;
      r_d         = r_next;
      in_frame_d  = 1'b1;
      if (!in_frame_q) mode_d = mode_check;
      if (in_last) begin
        if (frame_mode) begin
          out_last_d  = 1'b1;
          chk_valid_d = 1'b1;
          chk_ok_d    = (r_next == RESIDUE);
          r_d         = INIT;
          in_frame_d  = 1'b0;
`ifdef CRC_ERRCNT_EN
          if ((r_next != RESIDUE) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
`endif
        end else begin
          crc_d   = r_next ^ XOROUT;
          chunk_d = '0;
        end
      end
    end else if ((state_q == StAppend) && out_free) begin
      // crc_q is shifted so the next chunk always sits in the top DW bits.
      out_valid_d = 1'b1;
      out_data_d  = crc_q[WIDTH-1 -: DW];
      out_last_d  = last_chunk;
      crc_d       = crc_q << DW;
      chunk_d     = chunk_q + CntW'(1);
      if (last_chunk) begin
        r_d        = INIT;
        in_frame_d = 1'b0;
      end
    end else if (out_free) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= INIT;
      crc_q       <= '0;
      chunk_q     <= '0;
      in_frame_q  <= 1'b0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      chk_valid_q <= 1'b0;
      chk_ok_q    <= 1'b0;
`ifdef CRC_ERRCNT_EN
      err_q       <= '0;
`endif
    end else begin
      r_q         <= r_d;
      crc_q       <= crc_d;
      chunk_q     <= chunk_d;
      in_frame_q  <= in_frame_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      chk_valid_q <= chk_valid_d;
      chk_ok_q    <= chk_ok_d;
`ifdef CRC_ERRCNT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign chk_valid = chk_valid_q;
  assign chk_ok    = chk_ok_q;
  assign crc_value = r_q ^ XOROUT;
`ifdef CRC_ERRCNT_EN
  assign err_count = err_q;
`endif

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench for crc_stream: a DW=8 and a DW=1 instance driven with random frames and
// checked against a frame-level bit-serial CRC model.
module tb_crc_stream;

  localparam logic [7:0] PolyC    = 8'h39;
  localparam logic [7:0] InitC    = 8'hFF;
  localparam logic [7:0] XoroutC  = 8'h00;
  localparam logic [7:0] ResidueC = 8'h00;

  typedef struct packed {logic [7:0] d; logic l;} beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       m8 = 0, iv8 = 0, il8 = 0, or8 = 1;
  logic [7:0] id8 = '0;
  logic       ir8, ov8, ol8, cv8, ck8;
  logic [7:0] od8, cval8;
  logic       m1 = 0, iv1 = 0, il1 = 0, or1 = 1;
  logic [0:0] id1 = '0;
  logic       ir1, ov1, ol1, cv1, ck1;
  logic [0:0] od1;
  logic [7:0] cval1;
`ifdef CRC_ERRCNT_EN
  logic [15:0] ec8, ec1;
`endif

  crc_stream #(.WIDTH(8), .POLY(PolyC), .INIT(InitC), .XOROUT(XoroutC), .RESIDUE(ResidueC),
               .DW(8)) u_dut8 (
    .clk(clk), .rst(rst), .mode_check(m8), .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .in_last(il8), .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_last(ol8),
    .crc_value(cval8), .chk_valid(cv8), .chk_ok(ck8)
`ifdef CRC_ERRCNT_EN
    , .err_count(ec8)
`endif
  );

  crc_stream #(.WIDTH(8), .POLY(PolyC), .INIT(InitC), .XOROUT(XoroutC), .RESIDUE(ResidueC),
               .DW(1)) u_dut1 (
    .clk(clk), .rst(rst), .mode_check(m1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .in_last(il1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_last(ol1),
    .crc_value(cval1), .chk_valid(cv1), .chk_ok(ck1)
`ifdef CRC_ERRCNT_EN
    , .err_count(ec1)
`endif
  );

  int    errors = 0;
  int    checks = 0;
  bit    bp = 0;
  beat_t exp8[$];
  beat_t exp1[$];
  bit    chk8_q[$];
  bit    chk1_q[$];
  int    errc8 = 0;
  int    errc1 = 0;
  beat_t e8, e1;
  bit    c8, c1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Register value after shifting every frame bit (MSB of each beat first) through the CRC rule.
  function automatic logic [7:0] crc_reg(input logic [7:0] data[$], input int dw);
    logic [7:0] r;
    logic       fb;
    r = InitC;
    foreach (data[i]) begin
      for (int b = dw - 1; b >= 0; b--) begin
        fb = data[i][b] ^ r[7];
        r  = {r[6:0], 1'b0} ^ (fb ? PolyC : 8'h00);
      end
    end
    return r;
  endfunction

  task automatic push_exp(input int dw, input logic [7:0] d, input logic l);
    beat_t b;
    b.d = d;
    b.l = l;
    if (dw == 8) exp8.push_back(b);
    else         exp1.push_back(b);
  endtask

  task automatic drive(input int dw, input logic v, input logic [7:0] d, input logic l,
                       input logic m);
    if (dw == 8) begin
      iv8 = v; id8 = d; il8 = l; m8 = m;
    end else begin
      iv1 = v; id1 = d[0]; il1 = l; m1 = m;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the last beat is accepted.
  task automatic send(input int dw, input logic [7:0] data[$], input bit mode);
    logic [7:0] crc;
    int         nch, n, mask;
    logic       rdy, m;
    nch  = 8 / dw;
    mask = (1 << dw) - 1;
    crc  = crc_reg(data, dw);
    foreach (data[i]) push_exp(dw, data[i], mode && (i == data.size() - 1));
    if (mode) begin
      if (dw == 8) chk8_q.push_back(crc == ResidueC);
      else         chk1_q.push_back(crc == ResidueC);
    end else begin
      crc = crc ^ XoroutC;
      for (int k = 0; k < nch; k++)
        push_exp(dw, 8'((int'(crc) >> (8 - dw - k * dw)) & mask), k == nch - 1);
    end
    foreach (data[i]) begin
      // Mode is only meaningful on the first beat; scramble it afterwards.
      m = (i == 0) ? mode : 1'($urandom_range(0, 1));
      drive(dw, 1'b1, data[i], i == data.size() - 1, m);
      n = 0;
      do begin
        @(negedge clk);
        rdy = (dw == 8) ? ir8 : ir1;
        n++;
      end while (!rdy && n < 1000);
      if (!rdy) fail_now("in_ready_timeout", "no in_ready within 1000 cycles");
      @(posedge clk);
      #1;
    end
    drive(dw, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    or8 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    or1 = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (ov8 === 1'b1 && or8 === 1'b1) begin
      if (exp8.size() == 0) fail_now("unexpected_beat8", $sformatf("got data %0h", od8));
      else begin
        e8 = exp8.pop_front();
        check("out_data8", 32'(od8), 32'(e8.d));
        check("out_last8", 32'(ol8), 32'(e8.l));
      end
    end
    if (ov1 === 1'b1 && or1 === 1'b1) begin
      if (exp1.size() == 0) fail_now("unexpected_beat1", $sformatf("got data %0h", od1));
      else begin
        e1 = exp1.pop_front();
        check("out_data1", 32'(od1), 32'(e1.d[0]));
        check("out_last1", 32'(ol1), 32'(e1.l));
      end
    end
    if (cv8 === 1'b1) begin
      if (chk8_q.size() == 0) fail_now("unexpected_chk8", "chk_valid with no check frame");
      else begin
        c8 = chk8_q.pop_front();
        if (!c8) errc8++;
        check("chk_ok8", 32'(ck8), 32'(c8));
`ifdef CRC_ERRCNT_EN
        check("err_count8", 32'(ec8), errc8);
`endif
      end
    end
    if (cv1 === 1'b1) begin
      if (chk1_q.size() == 0) fail_now("unexpected_chk1", "chk_valid with no check frame");
      else begin
        c1 = chk1_q.pop_front();
        if (!c1) errc1++;
        check("chk_ok1", 32'(ck1), 32'(c1));
`ifdef CRC_ERRCNT_EN
        check("err_count1", 32'(ec1), errc1);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    bit         mode;
    int         len, n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(ov8), 0);
    check("rst_out_data", 32'(od8), 0);
    check("rst_out_last", 32'(ol8), 0);
    check("rst_chk_valid", 32'(cv8), 0);
    check("rst_chk_ok", 32'(ck8), 0);
    check("rst_crc_value", 32'(cval8), 32'(InitC ^ XoroutC));
    check("rst_in_ready", 32'(ir8), 1);
    check("rst_out_valid1", 32'(ov1), 0);
    check("rst_crc_value1", 32'(cval1), 32'(InitC ^ XoroutC));
    @(posedge clk);
    #1;

    // Generate {0x00}: data beat one cycle after acceptance, then the CRC beat.
    q = {8'h00};
    send(8, q, 1'b0);
    @(negedge clk);
    check("t1_latency_valid", 32'(ov8), 1);
    check("t1_data0", 32'(od8), 0);
    check("t1_last0", 32'(ol8), 0);
    check("t1_append_in_ready", 32'(ir8), 0);
    @(negedge clk);
    check("t1_crc_beat", 32'(od8), 32'(crc_reg(q, 8) ^ XoroutC));
    check("t1_crc_last", 32'(ol8), 1);
    @(posedge clk);
    #1;

    // Check good and bad trailing CRC.
    q = {8'h00, 8'h63};
    send(8, q, 1'b1);
    q = {8'h00, 8'h62};
    send(8, q, 1'b1);

    // Bit-serial generate of eight zero bits.
    q = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send(1, q, 1'b0);
    @(negedge clk);
    check("t3_crc_value1", 32'(cval1), 32'(crc_reg(q, 1) ^ XoroutC));
    @(posedge clk);
    #1;

    // Random back-to-back frames under backpressure, scrambled mid-frame mode.
    bp = 1;
    for (int f = 0; f < 40; f++) begin
      q.delete();
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) q.push_back(8'($urandom));
      if (mode && $urandom_range(0, 2) != 0) q.push_back(crc_reg(q, 8) ^ XoroutC);
      send(8, q, mode);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    for (int f = 0; f < 8; f++) begin
      logic [7:0] c;
      q.delete();
      mode = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) q.push_back(8'($urandom_range(0, 1)));
      if (mode && $urandom_range(0, 2) != 0) begin
        c = crc_reg(q, 1) ^ XoroutC;
        for (int b = 7; b >= 0; b--) q.push_back({7'd0, c[b]});
      end
      send(1, q, mode);
    end

    n = 0;
    while ((exp8.size() + exp1.size() + chk8_q.size() + chk1_q.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", exp8.size() + exp1.size() + chk8_q.size() + chk1_q.size(), 0);
    bp = 0;
    @(posedge clk);
    #1;

    // Reset while the CRC beat is pending: only the data beat ever appears.
    push_exp(8, 8'h00, 1'b0);
    drive(8, 1'b1, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    check("t6_in_ready", 32'(ir8), 1);
    @(posedge clk);
    #1;
    drive(8, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_out_valid", 32'(ov8), 0);
    check("t6_crc_value", 32'(cval8), 32'(InitC ^ XoroutC));
    check("t6_chk_valid", 32'(cv8), 0);
    repeat (10) @(negedge clk);
    check("final_exp8_empty", exp8.size(), 0);
    check("final_exp1_empty", exp1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/crc_stream.md
Name: crc_stream

Overview:
Parametrised CRC engine on a valid/ready stream, processing DW bits per cycle with configurable width, polynomial, init and xor-out.
- Generate mode: forwards each frame and appends its CRC as extra beats.
- Check mode: forwards each frame unchanged and reports whether the trailing CRC matched.
- Sits between a framed byte/bit source and a serial link or packet sink.

Parameters:
WIDTH, 8, CRC register width in bits
POLY, 8'h39, polynomial in truncated notation (x^WIDTH implied)
INIT, 8'hFF, register value at reset and at the start of each frame
XOROUT, 8'h00, value XORed into the register to form the CRC result
RESIDUE, 8'h00, check-mode register value after a good frame (CRC bits included)
DW, 1, data bits per beat; WIDTH % DW must be 0 and DW <= WIDTH, else elaboration error

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
mode_check  in  1  0=generate/append, 1=check; sampled on the first beat of each frame
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_data  in  DW  input data; in_data[DW-1] is processed first
in_last  in  1  final beat of frame
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  DW  output data
out_last  out  1  final output beat of frame
crc_value  out  WIDTH  live register XOR XOROUT
chk_valid  out  1  one-cycle pulse: check result available
chk_ok  out  1  result of the most recent check; held until the next chk_valid

Behaviour:
- Serial step per bit b: fb = b ^ r[WIDTH-1]; r = {r[WIDTH-2:0],0} ^ (fb ? POLY : 0). A beat applies DW steps combinationally, MSB first.
- Output register: loads when !out_valid || out_ready. Latency is one cycle from input acceptance to out_valid. Data passes through unchanged.
- States:
  - DATA:
    - in_ready = !out_valid || out_ready.
    - Each accepted beat updates r and sets in_frame.
    - The first beat (in_frame=0) latches mode_check; later changes to mode_check are ignored until the frame ends.
  - DATA, in_last accepted in generate mode:
    - Beat forwarded with out_last=0.
    - CRC latched as (r_next ^ XOROUT).
    - Chunk counter cleared; go to APPEND.
  - DATA, in_last accepted in check mode:
    - Beat forwarded with out_last=1.
    - Next cycle: chk_valid=1 and chk_ok=(r_next==RESIDUE).
    - r<=INIT, in_frame<=0; stay in DATA.
  - APPEND:
    - in_ready=0.
    - Emit WIDTH/DW chunks as the output register frees; chunk k = crc[WIDTH-1-k*DW -: DW].
    - Final chunk has out_last=1, then r<=INIT, in_frame<=0, go to DATA.
    - The next frame's first beat may be accepted the cycle after the final chunk loads.
- Backpressure: out_ready=0 stalls everything; no beat is dropped or duplicated. in_ready is combinational from out_valid/out_ready/state.
- Single-beat frame (first beat has in_last=1) is legal in both modes.
- Check-mode frame shorter than WIDTH/DW beats: still reports, with chk_ok computed per the rule above.
- Reset values: r=INIT, state=DATA, in_frame=0, out_valid=0, out_data=0, out_last=0, chk_valid=0, chk_ok=0. Reset mid-frame or mid-APPEND discards the frame immediately, with no partial CRC and no chk_valid.

Optional Feature:
CRC_ERRCNT_EN:
- Defined: adds output err_count[15:0] (reset 0), incremented on each chk_valid with chk_ok=0, saturating at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Generate, DW=8, out_ready=1: frame {0x00 last} -> outputs 0x00 (last=0), then 0x63 (last=1), one beat per cycle, 1-cycle latency.
2. Check, DW=8: frame {0x00, 0x63 last} -> chk_valid pulse with chk_ok=1. Frame {0x00, 0x62 last} -> chk_ok=0 (err_count=1 if CRC_ERRCNT_EN).
3. Generate, DW=1: bits 0,0,0,0,0,0,0,0 last -> 8 zero bits, then 0,1,1,0,0,0,1,1 with out_last on the final bit. crc_value is 0x63 after the 8th data bit.
4. Backpressure, DW=8: repeat test 1 with out_ready toggled 1,0,0,1,0,1... -> identical output sequence, in_ready=0 during APPEND, no loss or duplication.
5. Back-to-back: generate {0x00 last}, then check {0x00,0x63 last} with mode_check toggled mid-frame -> CRC appended to frame 1, chk_ok=1 for frame 2, mode of each frame fixed at its first beat.
6. Reset in APPEND after the 0x00 beat -> out_valid=0 next cycle, 0x63 never emitted, crc_value=INIT^XOROUT=0xFF, no chk_valid.
